// File: rtl/aurora_tx_block_scheduler_if.sv
// Block-slot interface between the TX block scheduler, the user sources and the 66-to-32 gearbox.
// The scheduler is the master; user logic and the gearbox sit on the slave side.
interface aurora_tx_block_scheduler_if;
  logic        gb_next;
  logic [65:0] data66;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ctrl_req;
  logic [7:0]  ctrl_btf;
  logic [55:0] ctrl_payload;
  logic        ctrl_ack;
  logic        link_run;
  logic        cc_active;

  modport master (
    input  gb_next, tx_data, tx_valid, ctrl_req, ctrl_btf, ctrl_payload,
    output data66, tx_ready, ctrl_ack, link_run, cc_active
  );

  modport slave (
    output gb_next, tx_data, tx_valid, ctrl_req, ctrl_btf, ctrl_payload,
    input  data66, tx_ready, ctrl_ack, link_run, cc_active
  );
endinterface

// File: rtl/aurora_tx_block_scheduler.sv
// Per-slot arbiter feeding the Aurora 64B/66B TX gearbox: CC insertion > control > data > idle.
// state | meaning
// INIT  | sending the post-reset idle run, user traffic blocked
// RUN   | normal per-slot arbitration
// CC    | remainder of a clock-compensation burst
module aurora_tx_block_scheduler #(
  parameter int          INIT_IDLES = 64,
  parameter int          CC_PERIOD  = 5000,
  parameter int          CC_LEN     = 3,
  parameter logic [65:0] IDLE_WORD  = {2'b10, 8'h78, 56'h0},
  parameter logic [65:0] CC_WORD    = {2'b10, 8'h78, 56'h80_0000_0000_0000}
) (
  input  logic                           clk,
  input  logic                           rst,
  aurora_tx_block_scheduler_if.master    bus
);

  localparam int IW = $clog2(INIT_IDLES + 1);
  localparam int CW = $clog2(CC_PERIOD + 1);
  localparam int BW = $clog2(CC_LEN + 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(INIT_IDLES - 1);
  localparam logic [CW-1:0] CC_DUE_CNT = CW'(CC_PERIOD - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(CC_LEN - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_CC   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] cc_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cc_due;
  logic          ctrl_pend;

  assign cc_due       = (state == ST_RUN) && (cc_cnt == CC_DUE_CNT);
  // The request is still high during its own ack cycle; that is not a new request.
  assign ctrl_pend    = bus.ctrl_req && !bus.ctrl_ack;
  assign bus.tx_ready = bus.gb_next && (state == ST_RUN) && !cc_due && !ctrl_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      idle_cnt      <= '0;
      cc_cnt        <= '0;
      burst_cnt     <= '0;
      bus.data66    <= IDLE_WORD;
      bus.ctrl_ack  <= 1'b0;
      bus.link_run  <= 1'b0;
      bus.cc_active <= 1'b0;
    end else begin
      bus.ctrl_ack <= 1'b0;
      if (bus.gb_next) begin
        case (state)
          ST_INIT: begin
            bus.data66    <= IDLE_WORD;
            bus.cc_active <= 1'b0;
            idle_cnt      <= idle_cnt + IW'(1);
            if (idle_cnt == IDLE_LAST) begin
              state        <= ST_RUN;
              bus.link_run <= 1'b1;
            end
          end
          ST_RUN: begin
            if (cc_due) begin
              // Period is measured burst start to burst start, so restart here.
              bus.data66    <= CC_WORD;
              bus.cc_active <= 1'b1;
              cc_cnt        <= '0;
              if (CC_LEN > 1) begin
                state     <= ST_CC;
                burst_cnt <= BW'(1);
              end
            end else begin
              cc_cnt        <= cc_cnt + CW'(1);
              bus.cc_active <= 1'b0;
              if (ctrl_pend) begin
                bus.data66   <= {2'b10, bus.ctrl_btf, bus.ctrl_payload};
                bus.ctrl_ack <= 1'b1;
              end else if (bus.tx_valid) begin
                bus.data66 <= {2'b01, bus.tx_data};
              end else begin
                bus.data66 <= IDLE_WORD;
              end
            end
          end
          ST_CC: begin
            bus.data66    <= CC_WORD;
            bus.cc_active <= 1'b1;
            cc_cnt        <= cc_cnt + CW'(1);
            if (burst_cnt == BURST_LAST) begin
              state     <= ST_RUN;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aurora_tx_block_scheduler.sv
// Randomized bench for the TX block scheduler against a slot-index reference model.
module tb_aurora_tx_block_scheduler;
  localparam int INIT_IDLES = 4;
  localparam int CC_PERIOD  = 8;
  localparam int CC_LEN     = 3;
  localparam logic [65:0] IDLE_WORD = {2'b10, 8'h78, 56'h0};
  localparam logic [65:0] CC_WORD   = {2'b10, 8'h78, 56'h80_0000_0000_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;

  aurora_tx_block_scheduler_if bus();

  aurora_tx_block_scheduler #(
    .INIT_IDLES(INIT_IDLES),
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN),
    .IDLE_WORD (IDLE_WORD),
    .CC_WORD   (CC_WORD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: slot k (0-based since RUN began) is CC when it falls in a burst window
  bit          m_run;
  int          m_idles;
  int          m_k;
  logic [65:0] m_data;
  bit          m_cc;
  bit          m_ack;
  bit          m_ack_prev;

  int gb_mode;     // 0: every cycle, 1: toggle, 2: random
  bit auto_valid;
  bit auto_ctrl;
  bit last_took;
  bit last_load;

  function automatic bit is_cc(int k);
    if (k < CC_PERIOD - 1) return 1'b0;
    return ((k - (CC_PERIOD - 1)) % CC_PERIOD) < CC_LEN;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_idles = 0; m_k = 0; m_data = IDLE_WORD;
    m_cc = 1'b0; m_ack = 1'b0; m_ack_prev = 1'b0;
  endtask

  task automatic chk(string tag, logic [65:0] obs, logic [65:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expire(string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s observed=bound expired expected=event within bound", tag);
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    logic exp_rdy;
    bit   nxt_ack;
    bit   took;
    #1;
    exp_rdy = bus.gb_next && m_run && !is_cc(m_k) && !(bus.ctrl_req && !m_ack);
    chk("tx_ready", {65'b0, bus.tx_ready}, {65'b0, exp_rdy});
    took    = 1'b0;
    nxt_ack = 1'b0;
    if (bus.gb_next) begin
      if (!m_run) begin
        m_data = IDLE_WORD; m_cc = 1'b0; m_idles++;
        if (m_idles == INIT_IDLES) m_run = 1'b1;
      end else begin
        if (is_cc(m_k)) begin
          m_data = CC_WORD; m_cc = 1'b1;
        end else if (bus.ctrl_req && !m_ack) begin
          m_data = {2'b10, bus.ctrl_btf, bus.ctrl_payload}; m_cc = 1'b0; nxt_ack = 1'b1;
        end else if (bus.tx_valid) begin
          m_data = {2'b01, bus.tx_data}; m_cc = 1'b0; took = 1'b1;
        end else begin
          m_data = IDLE_WORD; m_cc = 1'b0;
        end
        m_k++;
      end
    end
    m_ack_prev = m_ack;
    last_load  = bus.gb_next;
    @(posedge clk);
    #1;
    m_ack = nxt_ack;
    chk("data66",    bus.data66, m_data);
    chk("ctrl_ack",  {65'b0, bus.ctrl_ack},  {65'b0, m_ack});
    chk("cc_active", {65'b0, bus.cc_active}, {65'b0, m_cc});
    chk("link_run",  {65'b0, bus.link_run},  {65'b0, m_run});
    last_took = took;
    @(negedge clk);
    if (m_ack_prev) begin
      bus.ctrl_req = 1'b0;
    end else if (auto_ctrl && !bus.ctrl_req && $urandom_range(0, 7) == 0) begin
      bus.ctrl_req     = 1'b1;
      bus.ctrl_btf     = 8'($urandom);
      bus.ctrl_payload = {24'($urandom), $urandom};
    end
    if (took) begin
      bus.tx_data = {$urandom, $urandom};
      if (auto_valid) bus.tx_valid = 1'($urandom_range(0, 1));
    end else if (auto_valid && !bus.tx_valid) begin
      bus.tx_valid = 1'($urandom_range(0, 1));
    end
    case (gb_mode)
      0:       bus.gb_next = 1'b1;
      1:       bus.gb_next = !bus.gb_next;
      default: bus.gb_next = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  initial begin
    int n;
    int loads;
    int cc_seen;

    bus.gb_next = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    bus.ctrl_req = 1'b0; bus.ctrl_btf = '0; bus.ctrl_payload = '0;
    gb_mode = 1; auto_valid = 1'b0; auto_ctrl = 1'b0;
    last_took = 1'b0; last_load = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data66",    bus.data66, IDLE_WORD);
    chk("rst_link_run",  {65'b0, bus.link_run},  66'd0);
    chk("rst_cc_active", {65'b0, bus.cc_active}, 66'd0);
    chk("rst_ctrl_ack",  {65'b0, bus.ctrl_ack},  66'd0);

    // INIT with gb_next toggling 1,0,1,0 and data already offered
    @(negedge clk);
    rst = 1'b0;
    bus.gb_next  = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 64'h0123_4567_89AB_CDEF;
    n = 0; loads = 0;
    while (bus.link_run !== 1'b1 && n < 40) begin
      if (bus.gb_next) loads++;
      step(); n++;
    end
    if (n == 40) expire("init_done");
    chk_int("init_loads", loads, INIT_IDLES);

    n = 0;
    do begin step(); n++; end while (!last_took && n < 20);
    if (!last_took) expire("first_data");
    chk("data_word", bus.data66, 66'h1_0123_4567_89AB_CDEF);

    // control block beats waiting data, data takes the following slot
    bus.ctrl_req     = 1'b1;
    bus.ctrl_btf     = 8'h2D;
    bus.ctrl_payload = 56'h11_2233_4455_6677;
    n = 0;
    while (bus.ctrl_ack !== 1'b1 && n < 20) begin step(); n++; end
    if (n == 20) expire("ctrl_ack");
    chk("ctrl_word", bus.data66, {2'b10, 8'h2D, 56'h11_2233_4455_6677});
    n = 0; loads = 0;
    do begin
      step(); n++;
      if (last_load) loads++;
    end while (!last_took && n < 20);
    if (!last_took) expire("data_after_ctrl");
    chk_int("loads_to_data", loads, 1);
    chk("data_hdr", {64'b0, bus.data66[65:64]}, 66'd1);

    // continuous slots: any 2*CC_PERIOD consecutive loads hold exactly 2*CC_LEN CC blocks
    gb_mode = 0;
    bus.gb_next = 1'b1;
    cc_seen = 0;
    repeat (2 * CC_PERIOD) begin
      step();
      if (bus.data66 === CC_WORD) cc_seen++;
    end
    chk_int("cc_count", cc_seen, 2 * CC_LEN);

    // CC due, ctrl_req and tx_valid on the same slot
    n = 0;
    while (!(is_cc(m_k) && !is_cc(m_k - 1)) && n < 20) begin step(); n++; end
    if (n == 20) expire("burst_align");
    bus.ctrl_req     = 1'b1;
    bus.ctrl_btf     = 8'h1E;
    bus.ctrl_payload = 56'hA5_5AA5_5AA5_5AA5;
    n = 0;
    while (bus.ctrl_ack !== 1'b1 && n < 20) begin step(); n++; end
    chk_int("ack_after_burst", n, CC_LEN + 1);

    auto_valid = 1'b1; auto_ctrl = 1'b1; gb_mode = 2;
    repeat (500) step();

    // reset in the middle of a burst while gb_next is low
    auto_valid = 1'b0; auto_ctrl = 1'b0; gb_mode = 0;
    n = 0;
    while (bus.ctrl_req && n < 20) begin step(); n++; end
    bus.tx_valid = 1'b1;
    n = 0;
    while (!(m_cc && is_cc(m_k)) && n < 30) begin step(); n++; end
    if (n == 30) expire("mid_burst");
    bus.gb_next  = 1'b0;
    bus.ctrl_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_data66",    bus.data66, IDLE_WORD);
    chk("async_link_run",  {65'b0, bus.link_run},  66'd0);
    chk("async_cc_active", {65'b0, bus.cc_active}, 66'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    gb_mode = 1;
    bus.gb_next = 1'b1;
    n = 0; loads = 0;
    while (bus.ctrl_ack !== 1'b1 && n < 40) begin
      if (bus.gb_next) loads++;
      step(); n++;
    end
    chk_int("ack_after_init", loads, INIT_IDLES + 1);

    auto_valid = 1'b1; auto_ctrl = 1'b1; gb_mode = 2;
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
